instr_fetch_cache: RTL

Instruction-side responder at the far end of the PC unit's `instr_addr` output. It accepts a 16-bit fetch address each cycle and returns the 16-bit instruction from a direct-mapped, read-only instruction cache. On a miss it holds the pipeline with `stall` and refills one word from backing instruction memory through a request/acknowledge handshake. It sits between the PC unit / IF stage and the instruction memory model.

---
 rtl/instr_fetch_cache.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/instr_fetch_cache.sv
// Direct-mapped read-only instruction cache: one 16-bit word per line, single-word refill on miss.
// Latency: hit returns same cycle; miss delivers N+1 cycles after detect (N = request cycles to mem_ack).
// Backpressure: o_stall holds the PC while a refill is outstanding; o_mem_rd is held until i_mem_ack.
module instr_fetch_cache #(
    parameter int LINES = 8,
    parameter int IDXW  = $clog2(LINES)
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_addr,
    input  logic        i_rd,
    input  logic        i_flush,
    output logic [15:0] o_instr,
    output logic        o_instr_valid,
    output logic        o_stall,
    output logic        o_err,
    output logic        o_mem_rd,
    output logic [15:0] o_mem_addr,
    input  logic [15:0] i_mem_data,
    input  logic        i_mem_ack
);

    localparam int TAGW = 15 - IDXW;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_FILL = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [LINES-1:0]  r_valid;
    logic [TAGW-1:0]   r_tag  [LINES];
    logic [15:0]       r_data [LINES];

    logic [15:0]       r_mem_addr;
    logic [15:0]       r_fill;
    logic              r_flush_pending;

    logic [IDXW-1:0]   w_idx;
    logic [TAGW-1:0]   w_tag;
    logic [IDXW-1:0]   w_fill_idx;
    logic [TAGW-1:0]   w_fill_tag;
    logic              w_hit;
    logic              w_miss_start;
    logic              w_fill_we;

    assign w_idx      = i_addr[IDXW:1];
    assign w_tag      = i_addr[15:IDXW+1];
    assign w_fill_idx = r_mem_addr[IDXW:1];
    assign w_fill_tag = r_mem_addr[15:IDXW+1];

    // Lookup uses the valid bits as they stand this cycle, so a same-cycle flush does not affect it.
    assign w_hit = i_rd & ~i_addr[0] & r_valid[w_idx] & (r_tag[w_idx] == w_tag);

    assign o_mem_rd   = (r_state == S_REQ);
    assign o_mem_addr = r_mem_addr;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and fetch-side outputs.
    always_comb begin
        w_state_nxt   = r_state;
        o_instr       = 16'h0000;
        o_instr_valid = 1'b0;
        o_stall       = 1'b0;
        o_err         = 1'b0;
        w_miss_start  = 1'b0;
        w_fill_we     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_rd) begin
                    if (i_addr[0]) begin
                        // Misaligned fetch halts with a zero instruction; no cache or memory access.
                        o_err = 1'b1;
                    end else if (w_hit) begin
                        o_instr       = r_data[w_idx];
                        o_instr_valid = 1'b1;
                    end else begin
                        o_stall      = 1'b1;
                        w_miss_start = 1'b1;
                        w_state_nxt  = S_REQ;
                    end
                end
            end
            S_REQ: begin
                o_stall = 1'b1;
                if (i_mem_ack) begin
                    w_fill_we   = 1'b1;
                    w_state_nxt = S_FILL;
                end
            end
            S_FILL: begin
                // Deliver only if the PC is still on the missed address; otherwise IDLE re-evaluates.
                if (i_addr == r_mem_addr) begin
                    o_instr       = r_fill;
                    o_instr_valid = 1'b1;
                end else begin
                    o_stall = 1'b1;
                end
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Refill address/data capture, valid bits and deferred flush handling.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid         <= '0;
            r_mem_addr      <= 16'h0000;
            r_fill          <= 16'h0000;
            r_flush_pending <= 1'b0;
        end else begin
            if (w_miss_start) begin
                r_mem_addr <= {i_addr[15:1], 1'b0};
            end
            if (w_fill_we) begin
                r_fill <= i_mem_data;
            end
            if ((r_state == S_IDLE) && i_flush) begin
                r_valid <= '0;
            end
            if ((r_state != S_IDLE) && i_flush) begin
                r_flush_pending <= 1'b1;
            end
            // A flush seen during the miss means the refilled line must not be trusted.
            if (w_fill_we && !r_flush_pending && !i_flush) begin
                r_valid[w_fill_idx] <= 1'b1;
            end
            if (r_state == S_FILL) begin
                if (r_flush_pending || i_flush) begin
                    r_valid <= '0;
                end
                r_flush_pending <= 1'b0;
            end
        end
    end

    // Line payload write on acknowledge; validity alone decides whether it is ever read.
    always_ff @(posedge i_clk) begin
        if (w_fill_we && !i_rst) begin
            r_data[w_fill_idx] <= i_mem_data;
            r_tag[w_fill_idx]  <= w_fill_tag;
        end
    end

endmodule
